// File: rtl/core_mem_responder.sv
// core_mem_responder: fixed-latency instruction/data memory responder.
// Two independent request engines (fetch and data) share one word array.
// Reads are captured into output registers on the edge that enters the
// response cycle; stores commit on the edge that ends their response cycle.
// Handshake: a request is a one-cycle pulse accepted only when its engine is
// IDLE; the matching ready is a one-cycle pulse LATENCY cycles later, and the
// port is IDLE again in the cycle after that pulse.
module core_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int IMEM_LATENCY = 1,
    parameter int DMEM_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          pc_i,
    input  logic                           read_instr_i,
    output logic [DATA_WIDTH-1:0]          instr_o,
    output logic                           instr_ready_o,
    input  logic [ADDR_WIDTH-1:0]          dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]          dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        dmem_wstrb_i,
    input  logic                           dmem_read_i,
    input  logic                           dmem_write_i,
    output logic [DATA_WIDTH-1:0]          dmem_rdata_o,
    output logic                           dmem_ready_o,
    input  logic                           load_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0]          load_wdata_i,
    output logic                           protocol_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int ICW   = $clog2(IMEM_LATENCY + 1);
    localparam int DCW   = $clog2(DMEM_LATENCY + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } eng_state_e;

    // Byte-lane merge of store data onto an existing word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Storage array; deliberately not reset so preloaded programs survive.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // Fetch engine state
    eng_state_e            i_state_q, i_state_d;
    logic [ICW-1:0]        i_cnt_q, i_cnt_d;
    logic [IDX_W-1:0]      i_idx_q, i_idx_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  instr_ready_q, instr_ready_d;

    // Data engine state
    eng_state_e            d_state_q, d_state_d;
    logic [DCW-1:0]        d_cnt_q, d_cnt_d;
    logic [IDX_W-1:0]      d_idx_q, d_idx_d;
    logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;
    logic [NB-1:0]         d_wstrb_q, d_wstrb_d;
    logic                  d_is_wr_q, d_is_wr_d;
    logic [DATA_WIDTH-1:0] dmem_rdata_q, dmem_rdata_d;
    logic                  dmem_ready_q, dmem_ready_d;

    logic                  err_q, err_d;

    // Shared decode
    logic                  i_busy, d_busy;
    logic                  d_req, d_both;
    logic                  st_commit, ld_commit;
    logic [DATA_WIDTH-1:0] st_word;
    logic [DATA_WIDTH-1:0] i_rd_word, d_rd_word;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc_i[1:0], pc_i[ADDR_WIDTH-1:IDX_W+2],
                                dmem_addr_i[1:0], dmem_addr_i[ADDR_WIDTH-1:IDX_W+2]};

    // Commit conditions for the store engine and the side-band preload.
    always_comb begin
        i_busy    = (i_state_q == BUSY);
        d_busy    = (d_state_q == BUSY);
        d_req     = dmem_read_i | dmem_write_i;
        d_both    = dmem_read_i & dmem_write_i;
        st_commit = d_busy && (d_cnt_q == DCW'(1)) && d_is_wr_q;
        st_word   = merge_bytes(mem_q[d_idx_q], d_wdata_q, d_wstrb_q);
        ld_commit = load_we_i && !i_busy && !d_busy;
    end

    // Fetch engine next state and response data capture.
    always_comb begin
        i_state_d     = i_state_q;
        i_cnt_d       = i_cnt_q;
        i_idx_d       = i_idx_q;
        case (i_state_q)
            IDLE: begin
                if (read_instr_i) begin
                    i_state_d = BUSY;
                    i_cnt_d   = ICW'(IMEM_LATENCY);
                    i_idx_d   = pc_i[IDX_W+1:2];
                end
            end
            BUSY: begin
                if (i_cnt_q == ICW'(1)) begin
                    i_state_d = IDLE;
                    i_cnt_d   = '0;
                end else begin
                    i_cnt_d = i_cnt_q - ICW'(1);
                end
            end
            default: begin
                i_state_d = IDLE;
                i_cnt_d   = '0;
            end
        endcase
        instr_ready_d = (i_state_d == BUSY) && (i_cnt_d == ICW'(1));
        // A write landing on the same edge is forwarded into the captured word.
        i_rd_word = mem_q[i_idx_d];
        if (st_commit && (d_idx_q == i_idx_d)) begin
            i_rd_word = st_word;
        end
        if (ld_commit && (load_addr_i == i_idx_d)) begin
            i_rd_word = load_wdata_i;
        end
        instr_d = instr_ready_d ? i_rd_word : instr_q;
    end

    // Data engine next state and load data capture.
    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_idx_d   = d_idx_q;
        d_wdata_d = d_wdata_q;
        d_wstrb_d = d_wstrb_q;
        d_is_wr_d = d_is_wr_q;
        case (d_state_q)
            IDLE: begin
                if (d_req && !d_both) begin
                    d_state_d = BUSY;
                    d_cnt_d   = DCW'(DMEM_LATENCY);
                    d_idx_d   = dmem_addr_i[IDX_W+1:2];
                    d_wdata_d = dmem_wdata_i;
                    d_wstrb_d = dmem_wstrb_i;
                    d_is_wr_d = dmem_write_i;
                end
            end
            BUSY: begin
                if (d_cnt_q == DCW'(1)) begin
                    d_state_d = IDLE;
                    d_cnt_d   = '0;
                end else begin
                    d_cnt_d = d_cnt_q - DCW'(1);
                end
            end
            default: begin
                d_state_d = IDLE;
                d_cnt_d   = '0;
            end
        endcase
        dmem_ready_d = (d_state_d == BUSY) && (d_cnt_d == DCW'(1));
        d_rd_word = mem_q[d_idx_d];
        if (st_commit && (d_idx_q == d_idx_d)) begin
            d_rd_word = st_word;
        end
        if (ld_commit && (load_addr_i == d_idx_d)) begin
            d_rd_word = load_wdata_i;
        end
        dmem_rdata_d = (dmem_ready_d && !d_is_wr_d) ? d_rd_word : dmem_rdata_q;
    end

    // Sticky protocol error: busy-port requests, read+write, preload while busy.
    always_comb begin
        err_d = err_q
              | (read_instr_i && i_busy)
              | (d_req && d_busy)
              | d_both
              | (load_we_i && (i_busy || d_busy));
    end

    // Engine and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state_q     <= IDLE;
            i_cnt_q       <= '0;
            i_idx_q       <= '0;
            instr_q       <= '0;
            instr_ready_q <= 1'b0;
            d_state_q     <= IDLE;
            d_cnt_q       <= '0;
            d_idx_q       <= '0;
            d_wdata_q     <= '0;
            d_wstrb_q     <= '0;
            d_is_wr_q     <= 1'b0;
            dmem_rdata_q  <= '0;
            dmem_ready_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            i_state_q     <= i_state_d;
            i_cnt_q       <= i_cnt_d;
            i_idx_q       <= i_idx_d;
            instr_q       <= instr_d;
            instr_ready_q <= instr_ready_d;
            d_state_q     <= d_state_d;
            d_cnt_q       <= d_cnt_d;
            d_idx_q       <= d_idx_d;
            d_wdata_q     <= d_wdata_d;
            d_wstrb_q     <= d_wstrb_d;
            d_is_wr_q     <= d_is_wr_d;
            dmem_rdata_q  <= dmem_rdata_d;
            dmem_ready_q  <= dmem_ready_d;
            err_q         <= err_d;
        end
    end

    // Array writes: store commit at the end of its response cycle, or preload.
    always_ff @(posedge clk) begin
        if (st_commit) begin
            mem_q[d_idx_q] <= st_word;
        end else if (ld_commit) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
    end

    assign instr_o        = instr_q;
    assign instr_ready_o  = instr_ready_q;
    assign dmem_rdata_o   = dmem_rdata_q;
    assign dmem_ready_o   = dmem_ready_q;
    assign protocol_err_o = err_q;

endmodule
